branch_unit_p: RTL and testbench
================================

BRANCH_UNIT_P -- requirements
Module: branch_unit_p

Interface
REQ-001 Parameter PC_W, default 8, program counter width in bits (4..32).
REQ-002 Parameter DEPTH, default 2, pipeline stages from operand capture to WB outputs (1..4).
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset sampled on posedge clk.
REQ-005 op  input  11  decoded opcode, left-aligned; RI16 forms use op[2:10].
REQ-006 format  input  3  instruction format; 0 = RR, 5 = RI16; other values are non-branch.
REQ-007 rt_addr  input  7  link/destination register address.
REQ-008 ra  input  128  indirect target source; preferred slot is ra[0:31].
REQ-009 rt  input  128  condition source for conditional branches; preferred slot is rt[0:31].
REQ-010 imm  input  18  immediate; RI16 offset is imm[2:17].
REQ-011 reg_write  input  1  decode-stage write request for the link register.
REQ-012 pc_in  input  PC_W  PC of the issuing instruction.
REQ-013 flush  input  1  external squash of every in-flight entry.
REQ-014 rt_wb  output  128  link value.
REQ-015 rt_addr_wb  output  7  link destination.
REQ-016 reg_write_wb  output  1  link write enable.
REQ-017 pc_wb  output  PC_W  branch target.
REQ-018 branch_taken  output  1  redirect strobe, one cycle per taken branch.

Function
REQ-019 RR decode SHALL be: bi 00110101000, bisl 00110101001, biz 00100101000, binz 00100101001; RI16 op[2:10] decode SHALL be: br 001100100, bra 001100000, brsl 001100110, brasl 001100010, brz 001000000, brnz 001000010.
REQ-020 format 0 with op 0 (nop), and any undecoded op/format, SHALL enter the pipe as a bubble: all WB outputs 0.
REQ-021 Relative target SHALL be pc_in + sign-extended imm[2:17], truncated to PC_W bits (wraps modulo 2^PC_W); absolute target SHALL be sign-extended imm[2:17] truncated; indirect target SHALL be ra[32-PC_W:31].
REQ-022 The condition SHALL be rt[0:31] == 0 for brz/biz and != 0 for brnz/binz; unconditional forms are always taken.
REQ-023 Link forms (bisl, brsl, brasl) SHALL write rt_wb[0:31] = zero-extended pc_in + 1 (mod 2^PC_W), with rt_wb[32:127] = 0 and reg_write_wb = reg_write, whether or not the branch is taken.
REQ-024 Non-link forms SHALL drive reg_write_wb = 0 and rt_wb = 0.
REQ-025 Inputs sampled at edge N SHALL appear on WB outputs after edge N+DEPTH, one instruction per cycle, no stalls.
REQ-026 A not-taken branch SHALL drive branch_taken = 0 and pc_wb = 0.
REQ-027 When branch_taken = 1 in a cycle, every younger in-flight entry SHALL be converted to a bubble on the next edge; the instruction sampled on that same edge SHALL also be discarded.
REQ-028 flush = 1 SHALL bubble all stages and discard the instruction sampled on that edge; the WB outputs become 0 on the next edge.
REQ-029 flush and a taken WB branch in the same cycle SHALL act as a single squash; the branch_taken strobe already on the outputs is not retracted.

Reset
REQ-030 Reset SHALL zero rt_wb, rt_addr_wb, reg_write_wb, pc_wb, branch_taken and all stage registers on the next posedge; reset mid-operation SHALL discard all in-flight entries.

Configuration
REQ-031 With BRANCH_UNIT_P_STATS_EN defined, the block SHALL add outputs taken_cnt (16) and nottaken_cnt (16), saturating at 16'hFFFF, incremented when a branch reaches WB and cleared by reset; without the macro these ports and counters SHALL not exist.

Verification
REQ-032 DEPTH=2, PC_W=8: brsl with pc_in=8'h10, imm[2:17]=16'h0005, reg_write=1, rt_addr=3 -> two cycles later pc_wb=8'h15, branch_taken=1, rt_wb[0:31]=32'h11, rt_addr_wb=3, reg_write_wb=1.
REQ-033 br with pc_in=8'h02, imm[2:17]=16'hFFFC -> pc_wb=8'hFE, branch_taken=1 (wrap-around).
REQ-034 brz with rt[0:31]=1 -> branch_taken=0, pc_wb=0; brnz with the same rt -> branch_taken=1.
REQ-035 bi with ra[0:31]=32'h0000_0040, followed by two back-to-back br instructions -> one branch_taken pulse at pc_wb=8'h40; both younger br are squashed.
REQ-036 flush (or reset) asserted while two branches are in flight -> no branch_taken pulse; all outputs 0.

Source files
------------

// File: rtl/branch_unit_p.sv
// Branch unit: resolves RR/RI16 branch target, condition and link value at capture,
// then carries the result down a DEPTH-stage pipe to WB. Optional counters: BRANCH_UNIT_P_STATS_EN.
module branch_unit_p #(
   parameter int PC_W  = 8,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [10:0]     op,
   input  logic [2:0]      format,
   input  logic [6:0]      rt_addr,
   input  logic [127:0]    ra,
   input  logic [127:0]    rt,
   input  logic [17:0]     imm,
   input  logic            reg_write,
   input  logic [PC_W-1:0] pc_in,
   input  logic            flush,
   output logic [127:0]    rt_wb,
   output logic [6:0]      rt_addr_wb,
   output logic            reg_write_wb,
   output logic [PC_W-1:0] pc_wb,
   output logic            branch_taken
`ifdef BRANCH_UNIT_P_STATS_EN
   ,
   output logic [15:0]     taken_cnt,
   output logic [15:0]     nottaken_cnt
`endif
);

   // Buses are declared [N-1:0]: ISA bit 0 (big-endian numbering) is the MSB, so the
   // preferred slot [0:31] is [127:96] and the RI16 offset imm[2:17] is imm[15:0].
   typedef enum logic [1:0] {TGT_REL, TGT_ABS, TGT_IND} tgt_e;

   typedef struct packed {
      logic            is_br;
      logic            taken;
      logic [PC_W-1:0] target;
      logic            rw;
      logic [6:0]      addr;
      logic [PC_W-1:0] link_pc;
   } entry_t;

   logic            is_br;
   logic            is_link;
   logic            cond_z;
   logic            cond_nz;
   logic            rt_zero;
   logic            taken;
   tgt_e            tgt_sel;
   logic [PC_W-1:0] offset;
   logic [PC_W-1:0] target;
   entry_t          dec_next;
   entry_t          stage_reg [DEPTH+1];
   entry_t          wb;
   logic            squash;

   always_comb begin
      is_br   = 1'b0;
      is_link = 1'b0;
      cond_z  = 1'b0;
      cond_nz = 1'b0;
      tgt_sel = TGT_REL;
      if (format == 3'd0) begin
         case (op)
            11'b00110101000: begin is_br = 1'b1; tgt_sel = TGT_IND; end
            11'b00110101001: begin is_br = 1'b1; is_link = 1'b1; tgt_sel = TGT_IND; end
            11'b00100101000: begin is_br = 1'b1; cond_z = 1'b1; tgt_sel = TGT_IND; end
            11'b00100101001: begin is_br = 1'b1; cond_nz = 1'b1; tgt_sel = TGT_IND; end
            default: ;
         endcase
      end else if (format == 3'd5) begin
         case (op[8:0])
            9'b001100100: begin is_br = 1'b1; end
            9'b001100000: begin is_br = 1'b1; tgt_sel = TGT_ABS; end
            9'b001100110: begin is_br = 1'b1; is_link = 1'b1; end
            9'b001100010: begin is_br = 1'b1; is_link = 1'b1; tgt_sel = TGT_ABS; end
            9'b001000000: begin is_br = 1'b1; cond_z = 1'b1; end
            9'b001000010: begin is_br = 1'b1; cond_nz = 1'b1; end
            default: ;
         endcase
      end
   end

   assign rt_zero = (rt[127:96] == 32'd0);
   assign taken   = is_br && !(cond_z && !rt_zero) && !(cond_nz && rt_zero);
   assign offset  = PC_W'($signed(imm[15:0]));

   always_comb begin
      case (tgt_sel)
         TGT_REL: target = pc_in + offset;
         TGT_ABS: target = offset;
         default: target = ra[95+PC_W:96];
      endcase
   end

   // Not-taken branches and non-link forms leave their unused fields at zero.
   always_comb begin
      dec_next       = '0;
      dec_next.is_br = is_br;
      dec_next.taken = taken;
      if (taken) begin
         dec_next.target = target;
      end
      if (is_link) begin
         dec_next.rw      = reg_write;
         dec_next.addr    = rt_addr;
         dec_next.link_pc = pc_in + PC_W'(1);
      end
   end

   assign wb     = stage_reg[DEPTH];
   assign squash = flush || wb.taken;

   // Every in-flight entry is younger than WB, so any squash empties the whole pipe.
   always_ff @(posedge clk) begin
      if (reset || squash) begin
         for (int i = 0; i <= DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= dec_next;
         for (int i = 1; i <= DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign branch_taken = wb.taken;
   assign pc_wb        = wb.target;
   assign reg_write_wb = wb.rw;
   assign rt_addr_wb   = wb.addr;
   assign rt_wb        = {32'(wb.link_pc), 96'd0};

`ifdef BRANCH_UNIT_P_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         taken_cnt    <= '0;
         nottaken_cnt <= '0;
      end else if (wb.is_br) begin
         if (wb.taken) begin
            if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
         end else if (nottaken_cnt != 16'hFFFF) begin
            nottaken_cnt <= nottaken_cnt + 16'd1;
         end
      end
   end
`else
   logic unused_is_br;
   assign unused_is_br = wb.is_br;
`endif

   // Only the preferred slot and the 16-bit offset carry meaning here.
   logic unused_bits;
   assign unused_bits = ^{ra, rt[95:0], imm[17:16]};

endmodule

// File: tb/tb_branch_unit_p.sv
// Self-checking bench for branch_unit_p (PC_W=8, DEPTH=2): directed vector table,
// hand-written squash/reset sequences, and randomized traffic against a mnemonic-level model.
module tb_branch_unit_p;
   localparam int PC_W  = 8;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [10:0]     op;
   logic [2:0]      format;
   logic [6:0]      rt_addr;
   logic [127:0]    ra;
   logic [127:0]    rt;
   logic [17:0]     imm;
   logic            reg_write;
   logic [PC_W-1:0] pc_in;
   logic            flush;
   logic [127:0]    rt_wb;
   logic [6:0]      rt_addr_wb;
   logic            reg_write_wb;
   logic [PC_W-1:0] pc_wb;
   logic            branch_taken;

   always #5 clk = ~clk;

   branch_unit_p #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .op(op), .format(format), .rt_addr(rt_addr),
      .ra(ra), .rt(rt), .imm(imm), .reg_write(reg_write), .pc_in(pc_in), .flush(flush),
      .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
      .pc_wb(pc_wb), .branch_taken(branch_taken)
   );

   typedef enum int {M_NONE, M_BI, M_BISL, M_BIZ, M_BINZ, M_BR, M_BRA,
                     M_BRSL, M_BRASL, M_BRZ, M_BRNZ} mn_e;

   typedef struct {
      logic [2:0]  fmt;
      logic [10:0] op;
      logic [6:0]  addr;
      logic [31:0] ra_w;
      logic [31:0] rt_w;
      logic [15:0] imm16;
      logic        rw;
      logic [7:0]  pc;
   } in_t;

   typedef struct {
      logic        taken;
      logic [7:0]  pc;
      logic [31:0] link;
      logic [6:0]  addr;
      logic        rw;
      logic        chk_addr;
   } res_t;

   typedef struct {
      string name;
      in_t   in;
      res_t  exp;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic res_t mk_res(input logic t, input logic [7:0] pc, input logic [31:0] link,
                                   input logic [6:0] addr, input logic rw, input logic chk);
      res_t r;
      r.taken = t; r.pc = pc; r.link = link; r.addr = addr; r.rw = rw; r.chk_addr = chk;
      return r;
   endfunction

   function automatic res_t bubble();
      return mk_res(1'b0, 8'h00, 32'h0, 7'h0, 1'b0, 1'b1);
   endfunction

   function automatic in_t mk_raw(input logic [2:0] fmt, input logic [10:0] opc, input logic [6:0] addr,
                                  input logic [31:0] ra_w, input logic [31:0] rt_w,
                                  input logic [15:0] imm16, input logic rw, input logic [7:0] pc);
      in_t x;
      x.fmt = fmt; x.op = opc; x.addr = addr; x.ra_w = ra_w; x.rt_w = rt_w;
      x.imm16 = imm16; x.rw = rw; x.pc = pc;
      return x;
   endfunction

   // Encodes a mnemonic into format/op; M_NONE yields some non-branch encoding.
   function automatic in_t encode(input mn_e m, input in_t x);
      in_t y = x;
      case (m)
         M_BI:    begin y.fmt = 3'd0; y.op = 11'b00110101000; end
         M_BISL:  begin y.fmt = 3'd0; y.op = 11'b00110101001; end
         M_BIZ:   begin y.fmt = 3'd0; y.op = 11'b00100101000; end
         M_BINZ:  begin y.fmt = 3'd0; y.op = 11'b00100101001; end
         M_BR:    begin y.fmt = 3'd5; y.op = {2'($urandom), 9'b001100100}; end
         M_BRA:   begin y.fmt = 3'd5; y.op = {2'($urandom), 9'b001100000}; end
         M_BRSL:  begin y.fmt = 3'd5; y.op = {2'($urandom), 9'b001100110}; end
         M_BRASL: begin y.fmt = 3'd5; y.op = {2'($urandom), 9'b001100010}; end
         M_BRZ:   begin y.fmt = 3'd5; y.op = {2'($urandom), 9'b001000000}; end
         M_BRNZ:  begin y.fmt = 3'd5; y.op = {2'($urandom), 9'b001000010}; end
         default: begin
            y.fmt = 3'($urandom);
            y.op  = 11'($urandom);
            if ((y.fmt == 3'd0 && y.op inside {11'b00110101000, 11'b00110101001,
                                               11'b00100101000, 11'b00100101001}) ||
                (y.fmt == 3'd5 && y.op[8:0] inside {9'b001100100, 9'b001100000, 9'b001100110,
                                                    9'b001100010, 9'b001000000, 9'b001000010})) begin
               y.fmt = 3'd0;
               y.op  = 11'd0;
            end
            if ($urandom_range(0, 3) == 0) begin
               y.fmt = 3'd0;
               y.op  = 11'd0;
            end
         end
      endcase
      return y;
   endfunction

   function automatic in_t mk(input mn_e m, input logic [6:0] addr, input logic [31:0] ra_w,
                              input logic [31:0] rt_w, input logic [15:0] imm16,
                              input logic rw, input logic [7:0] pc);
      return encode(m, mk_raw(3'd0, 11'd0, addr, ra_w, rt_w, imm16, rw, pc));
   endfunction

   function automatic in_t nop_in();
      return mk_raw(3'd3, 11'd0, 7'd0, 32'd0, 32'd0, 16'd0, 1'b0, 8'd0);
   endfunction

   // Reference model: outcome of one instruction computed from its mnemonic with plain arithmetic.
   function automatic res_t model(input mn_e m, input in_t x);
      res_t        r;
      logic [31:0] tgt;
      logic        tk;
      r = bubble();
      if (m == M_NONE) return r;
      case (m)
         M_BI, M_BISL, M_BIZ, M_BINZ: tgt = x.ra_w;
         M_BRA, M_BRASL:              tgt = 32'($signed(x.imm16));
         default:                     tgt = 32'(int'(x.pc) + int'($signed(x.imm16)));
      endcase
      case (m)
         M_BIZ, M_BRZ:   tk = (x.rt_w == 32'd0);
         M_BINZ, M_BRNZ: tk = (x.rt_w != 32'd0);
         default:        tk = 1'b1;
      endcase
      r.taken = tk;
      r.pc    = tk ? 8'(tgt % 256) : 8'h00;
      if (m inside {M_BISL, M_BRSL, M_BRASL}) begin
         r.link = 32'((int'(x.pc) + 1) % 256);
         r.rw   = x.rw;
         r.addr = x.addr;
      end else begin
         r.chk_addr = 1'b0;
      end
      return r;
   endfunction

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_wb(input string tag, input res_t e);
      cmp({tag, ".branch_taken"}, 128'(branch_taken), 128'(e.taken));
      cmp({tag, ".pc_wb"},        128'(pc_wb),        128'(e.pc));
      cmp({tag, ".rt_wb"},        rt_wb,              {e.link, 96'd0});
      cmp({tag, ".reg_write_wb"}, 128'(reg_write_wb), 128'(e.rw));
      if (e.chk_addr) cmp({tag, ".rt_addr_wb"}, 128'(rt_addr_wb), 128'(e.addr));
   endtask

   task automatic drive(input in_t x, input logic fl, input logic rs);
      format    = x.fmt;
      op        = x.op;
      rt_addr   = x.addr;
      ra        = {x.ra_w, $urandom, $urandom, $urandom};
      rt        = {x.rt_w, $urandom, $urandom, $urandom};
      imm       = {2'($urandom), x.imm16};
      reg_write = x.rw;
      pc_in     = x.pc;
      flush     = fl;
      reset     = rs;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within 500000 time units");
      $fatal(1, "watchdog");
   end

   vec_t vt[$];
   res_t q[$];

   initial begin
      vt.push_back('{"brsl_basic",   mk(M_BRSL, 7'd3, 32'h0, 32'h0, 16'h0005, 1'b1, 8'h10), mk_res(1, 8'h15, 32'h11, 7'd3, 1, 1)});
      vt.push_back('{"br_wrap",      mk(M_BR, 7'd9, 32'h0, 32'h0, 16'hFFFC, 1'b1, 8'h02),   mk_res(1, 8'hFE, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"brz_nt",       mk(M_BRZ, 7'd0, 32'h0, 32'h1, 16'h0007, 1'b0, 8'h20),  mk_res(0, 8'h00, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"brnz_t",       mk(M_BRNZ, 7'd0, 32'h0, 32'h1, 16'h0007, 1'b0, 8'h20), mk_res(1, 8'h27, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"brz_t",        mk(M_BRZ, 7'd0, 32'h0, 32'h0, 16'h0007, 1'b0, 8'h20),  mk_res(1, 8'h27, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"brnz_nt",      mk(M_BRNZ, 7'd0, 32'h0, 32'h0, 16'h0007, 1'b0, 8'h20), mk_res(0, 8'h00, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"bra",          mk(M_BRA, 7'd0, 32'h0, 32'h0, 16'h0033, 1'b0, 8'h90),  mk_res(1, 8'h33, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"bra_neg",      mk(M_BRA, 7'd0, 32'h0, 32'h0, 16'hFF80, 1'b0, 8'h10),  mk_res(1, 8'h80, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"brasl_lwrap",  mk(M_BRASL, 7'h7F, 32'h0, 32'h0, 16'h0044, 1'b1, 8'hFF), mk_res(1, 8'h44, 32'h0, 7'h7F, 1, 1)});
      vt.push_back('{"bi",           mk(M_BI, 7'd0, 32'h12345678, 32'h0, 16'h0, 1'b0, 8'h00), mk_res(1, 8'h78, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"bisl",         mk(M_BISL, 7'd5, 32'h40, 32'h0, 16'h0, 1'b0, 8'h30),   mk_res(1, 8'h40, 32'h31, 7'd5, 0, 1)});
      vt.push_back('{"biz_t",        mk(M_BIZ, 7'd0, 32'h55, 32'h0, 16'h0, 1'b0, 8'h00),    mk_res(1, 8'h55, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"biz_nt",       mk(M_BIZ, 7'd0, 32'h55, 32'h100, 16'h0, 1'b0, 8'h00),  mk_res(0, 8'h00, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"binz_t",       mk(M_BINZ, 7'd0, 32'hAB, 32'h80000000, 16'h0, 1'b0, 8'h00), mk_res(1, 8'hAB, 32'h0, 7'd0, 0, 0)});
      vt.push_back('{"brsl_rw0",     mk(M_BRSL, 7'h11, 32'h0, 32'h0, 16'h8000, 1'b0, 8'h7F), mk_res(1, 8'h7F, 32'h80, 7'h11, 0, 1)});
      vt.push_back('{"nop",          mk_raw(3'd0, 11'd0, 7'd9, 32'h40, 32'h0, 16'h5, 1'b1, 8'h10), bubble()});
      vt.push_back('{"ri16_undec",   mk_raw(3'd5, 11'b00001100101, 7'd9, 32'h40, 32'h0, 16'h5, 1'b1, 8'h10), bubble()});
      vt.push_back('{"fmt3_bicode",  mk_raw(3'd3, 11'b00110101000, 7'd9, 32'h40, 32'h0, 16'h5, 1'b1, 8'h10), bubble()});
      vt.push_back('{"rr_undec",     mk_raw(3'd0, 11'b00001100100, 7'd9, 32'h40, 32'h0, 16'h5, 1'b1, 8'h10), bubble()});

      // Reset state
      drive(nop_in(), 1'b0, 1'b1);
      step();
      step();
      check_wb("reset_state", bubble());
      drive(nop_in(), 1'b0, 1'b0);
      step();

      // Table: one instruction each, with a latency check one cycle early.
      foreach (vt[i]) begin
         drive(vt[i].in, 1'b0, 1'b0);
         step();
         drive(nop_in(), 1'b0, 1'b0);
         repeat (DEPTH - 1) step();
         check_wb({vt[i].name, ".early"}, bubble());
         step();
         check_wb(vt[i].name, vt[i].exp);
         $display("vec %s: branch_taken=%0b pc_wb=%h rt_wb[127:96]=%h", vt[i].name, branch_taken, pc_wb, rt_wb[127:96]);
         step();
      end

      // bi followed by two back-to-back br: one pulse, both br squashed.
      drive(mk(M_BI, 7'd0, 32'h40, 32'h0, 16'h0, 1'b0, 8'h00), 1'b0, 1'b0);   step();
      drive(mk(M_BR, 7'd0, 32'h0, 32'h0, 16'h0010, 1'b0, 8'h01), 1'b0, 1'b0); step();
      drive(mk(M_BR, 7'd0, 32'h0, 32'h0, 16'h0010, 1'b0, 8'h02), 1'b0, 1'b0); step();
      drive(nop_in(), 1'b0, 1'b0);
      check_wb("bi_seq.bi", mk_res(1, 8'h40, 32'h0, 7'd0, 0, 0));
      step(); check_wb("bi_seq.br1", bubble());
      step(); check_wb("bi_seq.br2", bubble());
      step(); check_wb("bi_seq.tail", bubble());
      $display("seq bi+2br done");

      // Flush with two branches in flight, and the same with reset.
      for (int k = 0; k < 2; k++) begin
         drive(mk(M_BRZ, 7'd0, 32'h0, 32'h0, 16'h0001, 1'b0, 8'h10), 1'b0, 1'b0); step();
         drive(mk(M_BR, 7'd0, 32'h0, 32'h0, 16'h0001, 1'b0, 8'h20), 1'b0, 1'b0);  step();
         check_wb("squash_seq.pre", bubble());
         drive(mk(M_BR, 7'd0, 32'h0, 32'h0, 16'h0001, 1'b0, 8'h30), k == 0, k == 1); step();
         drive(nop_in(), 1'b0, 1'b0);
         check_wb(k == 0 ? "flush_seq.c0" : "reset_seq.c0", bubble()); step();
         check_wb(k == 0 ? "flush_seq.c1" : "reset_seq.c1", bubble()); step();
         check_wb(k == 0 ? "flush_seq.c2" : "reset_seq.c2", bubble()); step();
         $display("seq %s with two in flight done", k == 0 ? "flush" : "reset");
      end

      // Flush coinciding with a taken WB branch, then recovery.
      drive(mk(M_BI, 7'd0, 32'h60, 32'h0, 16'h0, 1'b0, 8'h00), 1'b0, 1'b0);   step();
      drive(mk(M_BR, 7'd0, 32'h0, 32'h0, 16'h0004, 1'b0, 8'h01), 1'b0, 1'b0); step();
      drive(mk(M_BR, 7'd0, 32'h0, 32'h0, 16'h0004, 1'b0, 8'h02), 1'b0, 1'b0); step();
      check_wb("flush_taken.bi", mk_res(1, 8'h60, 32'h0, 7'd0, 0, 0));
      drive(mk(M_BR, 7'd0, 32'h0, 32'h0, 16'h0004, 1'b0, 8'h03), 1'b1, 1'b0); step();
      drive(nop_in(), 1'b0, 1'b0);
      check_wb("flush_taken.c0", bubble()); step();
      check_wb("flush_taken.c1", bubble());
      drive(mk(M_BR, 7'd0, 32'h0, 32'h0, 16'h0003, 1'b0, 8'h05), 1'b0, 1'b0); step();
      drive(nop_in(), 1'b0, 1'b0);
      check_wb("flush_taken.c2", bubble()); step();
      check_wb("flush_taken.c3", bubble()); step();
      check_wb("flush_taken.recover", mk_res(1, 8'h08, 32'h0, 7'd0, 0, 0)); step();
      $display("seq flush+taken done");

      // Randomized traffic against the model; q[0] is the instruction due at WB now.
      for (int k = 0; k <= DEPTH; k++) q.push_back(bubble());
      for (int t = 0; t < 300; t++) begin
         mn_e  m;
         in_t  x;
         logic fl;
         logic rs;
         check_wb("rnd", q[0]);
         m  = mn_e'($urandom_range(0, 10));
         fl = ($urandom_range(0, 19) == 0);
         rs = ($urandom_range(0, 49) == 0);
         x  = mk_raw(3'd0, 11'd0, 7'($urandom), $urandom,
                     ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom,
                     16'($urandom), 1'($urandom), 8'($urandom));
         x  = encode(m, x);
         drive(x, fl, rs);
         $display("txn %0d: %s fmt=%0d op=%h pc=%h flush=%0b reset=%0b", t, m.name(), x.fmt, x.op, x.pc, fl, rs);
         if (rs || fl || q[0].taken) begin
            foreach (q[i]) q[i] = bubble();
         end else begin
            q.push_back(model(m, x));
            void'(q.pop_front());
         end
         step();
      end
      check_wb("rnd.last", q[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
